// File: rtl/wb_stage.sv
// wb_stage: write-back stage downstream of EX.
// Drives the single register-bank write port, owns the architectural flag
// register fed back to EX, and stalls EX through ex_ready while a
// data-memory load completes.
// Optional feature macro: WB_FLAG_BYPASS_EN (forward ALU flags to rf_* in the
// same cycle as a flag-writing ALU transfer).
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_O,
    input  logic              alu_S,
    input  logic              alu_C,
    input  logic              alu_Z,
    input  logic [DATA_W-1:0] dm_Q,
    input  logic              uc_S_MXWB,
    input  logic              uc_WR,
    input  logic              uc_WF,
    input  logic [ADDR_W-1:0] uc_RD,
    output logic              rb_WE,
    output logic [ADDR_W-1:0] rb_WA,
    output logic [DATA_W-1:0] rb_WD,
    output logic              rf_O,
    output logic              rf_S,
    output logic              rf_C,
    output logic              rf_Z,
    output logic [31:0]       retired
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    // Counter preload: a load spends DM_LAT cycles in LOAD_WAIT, the last
    // one being the cycle in which the counter reads zero.
    localparam logic [2:0] LOAD_CNT = 3'(DM_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [2:0]        counter;
    logic [ADDR_W-1:0] pend_rd;
    logic              pend_wr;
    logic              flag_o;
    logic              flag_s;
    logic              flag_c;
    logic              flag_z;
    logic              transfer;

    // Handshake: ready depends on state only, never on ex_valid.
    always_comb begin
        ex_ready = (state == IDLE);
        transfer = ex_valid && ex_ready;
    end

    // Next-state logic: loads park in LOAD_WAIT until the read data is due.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (transfer && uc_S_MXWB) state_next = LOAD_WAIT;
            LOAD_WAIT: if (counter == 3'd0) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Write port, flag register, pending-load bookkeeping and retire count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            counter <= 3'd0;
            pend_rd <= '0;
            pend_wr <= 1'b0;
            rb_WE   <= 1'b0;
            rb_WA   <= '0;
            rb_WD   <= '0;
            flag_o  <= 1'b0;
            flag_s  <= 1'b0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            retired <= 32'd0;
        end else begin
            rb_WE <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        if (!uc_S_MXWB) begin
                            rb_WD   <= alu_result;
                            rb_WA   <= uc_RD;
                            rb_WE   <= uc_WR;
                            retired <= retired + 32'd1;
                            if (uc_WF) begin
                                flag_o <= alu_O;
                                flag_s <= alu_S;
                                flag_c <= alu_C;
                                flag_z <= alu_Z;
                            end
                        end else begin
                            pend_rd <= uc_RD;
                            pend_wr <= uc_WR;
                            counter <= LOAD_CNT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (counter != 3'd0) begin
                        counter <= counter - 3'd1;
                    end else begin
                        rb_WD   <= dm_Q;
                        rb_WA   <= pend_rd;
                        rb_WE   <= pend_wr;
                        retired <= retired + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WB_FLAG_BYPASS_EN
    // Forward fresh ALU flags to EX in the accepting cycle for a zero-bubble
    // flag dependency; the register itself still updates at the edge.
    always_comb begin
        if (transfer && !uc_S_MXWB && uc_WF) begin
            rf_O = alu_O;
            rf_S = alu_S;
            rf_C = alu_C;
            rf_Z = alu_Z;
        end else begin
            rf_O = flag_o;
            rf_S = flag_s;
            rf_C = flag_c;
            rf_Z = flag_z;
        end
    end
`else
    // Flags seen by EX are the registered values only.
    always_comb begin
        rf_O = flag_o;
        rf_S = flag_s;
        rf_C = flag_c;
        rf_Z = flag_z;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage.
// Two instances share the stimulus: dut1 with DM_LAT = 1, dut3 with DM_LAT = 3.
// Expected register writes are queued when an instruction is driven and
// popped when the watched instance asserts rb_WE.
module tb_wb_stage;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic        a_o, a_s, a_c, a_z;
    logic [31:0] dm_q;
    logic        s_mxwb;
    logic        wr;
    logic        wf;
    logic [4:0]  rd;

    logic        ready1, we1, o1, s1, c1, z1;
    logic [4:0]  wa1;
    logic [31:0] wd1, ret1;
    logic        ready3, we3, o3, s3, c3, z3;
    logic [4:0]  wa3;
    logic [31:0] wd3, ret3;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t e;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .DM_LAT(1)) dut1 (
        .CLK(clk), .RST(rst), .ex_valid(ex_valid), .ex_ready(ready1),
        .alu_result(alu_result), .alu_O(a_o), .alu_S(a_s), .alu_C(a_c), .alu_Z(a_z),
        .dm_Q(dm_q), .uc_S_MXWB(s_mxwb), .uc_WR(wr), .uc_WF(wf), .uc_RD(rd),
        .rb_WE(we1), .rb_WA(wa1), .rb_WD(wd1),
        .rf_O(o1), .rf_S(s1), .rf_C(c1), .rf_Z(z1), .retired(ret1)
    );

    wb_stage #(.DATA_W(32), .ADDR_W(5), .DM_LAT(3)) dut3 (
        .CLK(clk), .RST(rst), .ex_valid(ex_valid), .ex_ready(ready3),
        .alu_result(alu_result), .alu_O(a_o), .alu_S(a_s), .alu_C(a_c), .alu_Z(a_z),
        .dm_Q(dm_q), .uc_S_MXWB(s_mxwb), .uc_WR(wr), .uc_WF(wf), .uc_RD(rd),
        .rb_WE(we3), .rb_WA(wa3), .rb_WD(wd3),
        .rf_O(o3), .rf_S(s3), .rf_C(c3), .rf_Z(z3), .retired(ret3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction; flags packed as {O,S,C,Z}.
    task automatic drive_op(input logic v, input logic mx, input logic w, input logic f,
                            input logic [4:0] r, input logic [31:0] res, input logic [3:0] fl);
        ex_valid   = v;
        s_mxwb     = mx;
        wr         = w;
        wf         = f;
        rd         = r;
        alu_result = res;
        {a_o, a_s, a_c, a_z} = fl;
    endtask

    task automatic idle_inputs();
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'b0000);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        idle_inputs();
        repeat (n) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic seen;
        apply_reset(2);
        dm_q = 32'h1111_2222;
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 4'b1111);
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 4'b0000);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (ready3 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pre_stall: ready3=%b want 0", ready3);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (we1 !== 1'b0 || wa1 !== 5'd0 || wd1 !== 32'd0 || ret1 !== 32'd0 || ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_dut1: we=%b wa=%0d wd=%h ret=%0d ready=%b want 0 0 0 0 1",
                     we1, wa1, wd1, ret1, ready1);
        end
        checks++;
        if ({o1, s1, c1, z1} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {o1, s1, c1, z1});
        end
        checks++;
        if (we3 !== 1'b0 || ret3 !== 32'd0 || ready3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_dut3: we=%b ret=%0d ready=%b want 0 0 1", we3, ret3, ready3);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (we1 === 1'b1 || we3 === 1'b1 || ret1 !== 32'd0 || ret3 !== 32'd0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_dropped_load: write_seen=%b want 0", seen);
        end
    endtask

    task automatic test_alu_write();
        apply_reset(1);
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0003, 4'b0010);
        exp_q.push_back('{wa: 5'd5, wd: 32'h0000_0003});
        @(negedge clk);
        checks++;
        if (we1 !== 1'b1) begin
            errors++; $display("[TB] FAIL alu_we: got %b want 1", we1);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("[TB] FAIL alu_data: no expected write queued");
        end else begin
            e = exp_q.pop_front();
            if (wa1 !== e.wa || wd1 !== e.wd) begin
                errors++; $display("[TB] FAIL alu_data: wa=%0d wd=%h want wa=%0d wd=%h", wa1, wd1, e.wa, e.wd);
            end
        end
        checks++;
        if (c1 !== 1'b1 || z1 !== 1'b0 || ret1 !== 32'd1) begin
            errors++; $display("[TB] FAIL alu_flags_ret: C=%b Z=%b ret=%0d want 1 0 1", c1, z1, ret1);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (we1 !== 1'b0) begin
            errors++; $display("[TB] FAIL alu_pulse: we=%b want 0", we1);
        end
    endtask

    task automatic test_load_lat1();
        apply_reset(1);
        dm_q = 32'h0BAD_0BAD;
        drive_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 4'b1011);
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'd0, 4'b0000);
        exp_q.push_back('{wa: 5'd7, wd: 32'hDEAD_BEEF});
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b0 || we1 !== 1'b0) begin
            errors++; $display("[TB] FAIL load1_stall: ready=%b we=%b want 0 0", ready1, we1);
        end
        idle_inputs();
        dm_q = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || we1 !== 1'b1) begin
            errors++; $display("[TB] FAIL load1_done: ready=%b we=%b want 1 1", ready1, we1);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("[TB] FAIL load1_data: no expected write queued");
        end else begin
            e = exp_q.pop_front();
            if (wa1 !== e.wa || wd1 !== e.wd) begin
                errors++; $display("[TB] FAIL load1_data: wa=%0d wd=%h want wa=%0d wd=%h", wa1, wd1, e.wa, e.wd);
            end
        end
        checks++;
        if ({o1, s1, c1, z1} !== 4'b1011 || ret1 !== 32'd2) begin
            errors++; $display("[TB] FAIL load1_flags_ret: flags=%b ret=%0d want 1011 2", {o1, s1, c1, z1}, ret1);
        end
    endtask

    task automatic test_load_lat3();
        int low_cnt;
        apply_reset(1);
        dm_q = 32'd0;
        drive_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'd0, 4'b0000);
        exp_q.push_back('{wa: 5'd12, wd: 32'hCAFE_F00D});
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0055, 4'b0000);
        exp_q.push_back('{wa: 5'd3, wd: 32'h0000_0055});
        dm_q = 32'hCAFE_F00D;
        low_cnt = 0;
        while (ready3 === 1'b0 && low_cnt < 10) begin
            low_cnt++;
            @(negedge clk);
        end
        checks++;
        if (low_cnt != 3) begin
            errors++; $display("[TB] FAIL load3_stall_len: got %0d cycles want 3", low_cnt);
        end
        checks++;
        if (exp_q.size() == 0 || we3 !== 1'b1 || ret3 !== 32'd1) begin
            errors++; $display("[TB] FAIL load3_write: we=%b ret=%0d want 1 1", we3, ret3);
        end else begin
            e = exp_q.pop_front();
            if (wa3 !== e.wa || wd3 !== e.wd) begin
                errors++; $display("[TB] FAIL load3_write: wa=%0d wd=%h want wa=%0d wd=%h", wa3, wd3, e.wa, e.wd);
            end
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (exp_q.size() == 0 || we3 !== 1'b1 || ret3 !== 32'd2) begin
            errors++; $display("[TB] FAIL load3_second: we=%b ret=%0d want 1 2", we3, ret3);
        end else begin
            e = exp_q.pop_front();
            if (wa3 !== e.wa || wd3 !== e.wd) begin
                errors++; $display("[TB] FAIL load3_second: wa=%0d wd=%h want wa=%0d wd=%h", wa3, wd3, e.wa, e.wd);
            end
        end
    endtask

    task automatic test_flag_hold();
        apply_reset(1);
        drive_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 4'b0010);
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0000_A5A5, 4'b1101);
        exp_q.push_back('{wa: 5'd2, wd: 32'h0000_A5A5});
        @(negedge clk);
        checks++;
        if ({o1, s1, c1, z1} !== 4'b0010) begin
            errors++; $display("[TB] FAIL flag_hold: flags=%b want 0010", {o1, s1, c1, z1});
        end
        checks++;
        if (exp_q.size() == 0 || we1 !== 1'b1) begin
            errors++; $display("[TB] FAIL flag_hold_write: we=%b want 1", we1);
        end else begin
            e = exp_q.pop_front();
            if (wa1 !== e.wa || wd1 !== e.wd) begin
                errors++; $display("[TB] FAIL flag_hold_write: wa=%0d wd=%h want wa=%0d wd=%h", wa1, wd1, e.wa, e.wd);
            end
        end
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h1234_5678, 4'b0000);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (we1 !== 1'b0 || ret1 !== 32'd3) begin
            errors++; $display("[TB] FAIL store_retire: we=%b ret=%0d want 0 3", we1, ret1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        apply_reset(1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                checks++;
                if (exp_q.size() == 0 || we1 !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_we[%0d]: we=%b want 1", i, we1);
                end else begin
                    e = exp_q.pop_front();
                    if (wa1 !== e.wa || wd1 !== e.wd) begin
                        errors++; $display("[TB] FAIL b2b_data[%0d]: wa=%0d wd=%h want wa=%0d wd=%h",
                                           i, wa1, wd1, e.wa, e.wd);
                    end
                end
            end
            if (i < 4) begin
                d = $urandom;
                drive_op(1'b1, 1'b0, 1'b1, 1'b0, 5'(i + 10), d, 4'b0000);
                exp_q.push_back('{wa: 5'(i + 10), wd: d});
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        checks++;
        if (we1 !== 1'b0 || ret1 !== 32'd4) begin
            errors++; $display("[TB] FAIL b2b_end: we=%b ret=%0d want 0 4", we1, ret1);
        end
    endtask

    task automatic test_wrap();
        apply_reset(1);
        force dut1.retired = 32'hFFFF_FFFF;
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0000_1234, 4'b0001);
        exp_q.push_back('{wa: 5'd1, wd: 32'h0000_1234});
        #1;
        release dut1.retired;
        checks++;
`ifdef WB_FLAG_BYPASS_EN
        if (z1 !== 1'b1) begin
            errors++; $display("[TB] FAIL bypass_z: got %b want 1", z1);
        end
`else
        if (z1 !== 1'b0) begin
            errors++; $display("[TB] FAIL no_bypass_z: got %b want 0", z1);
        end
`endif
        @(negedge clk);
        idle_inputs();
        checks++;
        if (ret1 !== 32'd0 || z1 !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap: ret=%h Z=%b want 00000000 1", ret1, z1);
        end
        checks++;
        if (exp_q.size() == 0 || we1 !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap_write: we=%b want 1", we1);
        end else begin
            e = exp_q.pop_front();
            if (wa1 !== e.wa || wd1 !== e.wd) begin
                errors++; $display("[TB] FAIL wrap_write: wa=%0d wd=%h want wa=%0d wd=%h", wa1, wd1, e.wa, e.wd);
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst  = 1'b1;
        dm_q = 32'd0;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_lat1();
        test_load_lat3();
        test_flag_hold();
        test_back_to_back();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
